// File: rtl/fft_sep_pkg.sv
// fft_sep_pkg: shared types and defaults for the FFT peak separator.
// Holds the FSM state encoding, the default FFT geometry, the peak record
// and the bin-distance helper used for the exclusion zone around peak1.
package fft_sep_pkg;

  localparam int N_FFT_DEF  = 2048;
  localparam int LOG2_N_DEF = 11;
  localparam int FS_HZ_DEF  = 500000;

  localparam int MAG_W  = 28;
  localparam int BIN_W  = 11;
  localparam int FREQ_W = 20;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_COLLECT = 3'd1;
  localparam state_t ST_H1_RD   = 3'd2;
  localparam state_t ST_H1_CMP  = 3'd3;
  localparam state_t ST_H2_RD   = 3'd4;
  localparam state_t ST_H2_CMP  = 3'd5;
  localparam state_t ST_CALC    = 3'd6;
  localparam state_t ST_DONE    = 3'd7;

  typedef struct packed {
    logic [27:0] mag;
    logic [10:0] bin;
  } peak_t;

  // Absolute distance between two bin numbers.
  function automatic logic [10:0] bin_dist(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/fft_half_spec_ram.sv
// fft_half_spec_ram: 1024 x 28 simple dual-port RAM holding the lower half
// of the magnitude spectrum. One write port, one read port with a
// registered (one-cycle) read. Only built with SIG_SEP_WAVE_CLASS_EN.
module fft_half_spec_ram
  import fft_sep_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [9:0]       wr_addr,
  input  logic [MAG_W-1:0] wr_data,
  input  logic [9:0]       rd_addr,
  output logic [MAG_W-1:0] rd_data
);

  logic [MAG_W-1:0] mem [0:1023];

  // Write the incoming bin and return the addressed word one cycle later
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_peak_separator.sv
// fft_peak_separator: tracks the two strongest peaks of one FFT frame,
// converts their bins to Hz and publishes them with a one-cycle result_valid.
// Build option SIG_SEP_WAVE_CLASS_EN adds the half-spectrum RAM and the
// 3rd-harmonic sine/triangle classification; without it is_tri is tied 0.
module fft_peak_separator
  import fft_sep_pkg::*;
#(
  parameter int          N_FFT       = N_FFT_DEF,
  parameter int          LOG2_N      = LOG2_N_DEF,
  parameter int          FS_HZ       = FS_HZ_DEF,
  parameter int          MIN_BIN     = 4,
  parameter int          GUARD       = 3,
  parameter logic [27:0] NOISE_FLOOR = 28'd1000
`ifdef SIG_SEP_WAVE_CLASS_EN
  ,
  parameter int          TRI_SHIFT   = 4
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [27:0] magnitude,
  input  logic [10:0] bin_index,
  input  logic        magnitude_valid,
  input  logic        processing_done,
  output logic        busy,
  output logic        result_valid,
  output logic [10:0] peak1_bin,
  output logic [10:0] peak2_bin,
  output logic [27:0] peak1_mag,
  output logic [27:0] peak2_mag,
  output logic [19:0] peak1_freq_hz,
  output logic [19:0] peak2_freq_hz,
  output logic        peak1_is_tri,
  output logic        peak2_is_tri,
  output logic        peak2_found
);

  localparam logic [10:0] HALF_B  = 11'(N_FFT / 2);
  localparam logic [10:0] MIN_B   = 11'(MIN_BIN);
  localparam logic [10:0] GUARD_B = 11'(GUARD);
  localparam logic [29:0] FS_W    = 30'(FS_HZ);

`ifdef SIG_SEP_WAVE_CLASS_EN
  localparam state_t ST_AFTER_COLLECT = ST_H1_RD;
`else
  localparam state_t ST_AFTER_COLLECT = ST_CALC;
`endif

  state_t      state;
  peak_t       p1, p2;
  peak_t       base1, base2, next1, next2, kept;
  logic        take_bin, in_half, qualifies;
  logic [29:0] prod1, prod2;
  logic [19:0] freq1, freq2;

  // Fold the bin presented this cycle into the working peak pair
  always_comb begin
    take_bin  = enable && magnitude_valid && ((state == ST_IDLE) || (state == ST_COLLECT));
    in_half   = (bin_index < HALF_B);
    qualifies = in_half && (bin_index >= MIN_B);
    base1     = p1;
    base2     = p2;
    if ((state == ST_IDLE) || (bin_index == '0)) begin
      base1 = '0;
      base2 = '0;
    end
    next1 = base1;
    next2 = base2;
    kept  = base2;
    if (qualifies) begin
      if (magnitude > base1.mag) begin
        kept = (bin_dist(bin_index, base1.bin) > GUARD_B) ? base1 : base2;
        if (bin_dist(kept.bin, bin_index) <= GUARD_B) begin
          kept = '0;
        end
        next1 = '{mag: magnitude, bin: bin_index};
        next2 = kept;
      end else if ((magnitude > base2.mag) && (bin_dist(bin_index, base1.bin) > GUARD_B)) begin
        next2 = '{mag: magnitude, bin: bin_index};
      end
    end
  end

  // Working peaks follow every accepted bin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0;
      p2 <= '0;
    end else if (take_bin) begin
      p1 <= next1;
      p2 <= next2;
    end
  end

  // Frame sequencing; dropping enable abandons the frame and keeps old results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else if (!enable) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (magnitude_valid) begin
            state <= ST_COLLECT;
            busy  <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (processing_done) begin
            state <= ST_AFTER_COLLECT;
          end
        end
`ifdef SIG_SEP_WAVE_CLASS_EN
        ST_H1_RD:  state <= ST_H1_CMP;
        ST_H1_CMP: state <= ST_H2_RD;
        ST_H2_RD:  state <= ST_H2_CMP;
        ST_H2_CMP: state <= ST_CALC;
`endif
        ST_CALC:   state <= ST_DONE;
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

`ifdef SIG_SEP_WAVE_CLASS_EN
  peak_t       rd_peak;
  logic [11:0] h_addr;
  logic [27:0] ram_q;
  logic        wr_en;
  logic        tri_hit;
  logic        tri1, tri2;

  // Address the 3rd harmonic of the peak being examined and judge its strength
  always_comb begin
    rd_peak = ((state == ST_H1_RD) || (state == ST_H1_CMP)) ? p1 : p2;
    h_addr  = 12'(rd_peak.bin) * 12'd3;
    tri_hit = (h_addr < 12'(HALF_B)) && (rd_peak.mag != '0) &&
              ((32'(ram_q) << TRI_SHIFT) >= 32'(rd_peak.mag));
    wr_en   = take_bin && in_half;
  end

  fft_half_spec_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (bin_index[9:0]),
    .wr_data (magnitude),
    .rd_addr (h_addr[9:0]),
    .rd_data (ram_q)
  );

  // Capture each harmonic verdict as its lookup returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri1 <= 1'b0;
      tri2 <= 1'b0;
    end else if (enable) begin
      if (state == ST_H1_CMP) tri1 <= tri_hit;
      if (state == ST_H2_CMP) tri2 <= tri_hit;
    end
  end
`else
  assign peak1_is_tri = 1'b0;
  assign peak2_is_tri = 1'b0;
`endif

  // Bin-to-Hz products; the low LOG2_N bits are dropped to divide by N_FFT
  always_comb begin
    prod1 = 30'(p1.bin) * FS_W;
    prod2 = 30'(p2.bin) * FS_W;
  end

  // Frequencies settle in CALC, then the whole result is published in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq1         <= '0;
      freq2         <= '0;
      result_valid  <= 1'b0;
      peak1_bin     <= '0;
      peak2_bin     <= '0;
      peak1_mag     <= '0;
      peak2_mag     <= '0;
      peak1_freq_hz <= '0;
      peak2_freq_hz <= '0;
      peak2_found   <= 1'b0;
`ifdef SIG_SEP_WAVE_CLASS_EN
      peak1_is_tri  <= 1'b0;
      peak2_is_tri  <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      if (enable && (state == ST_CALC)) begin
        freq1 <= 20'(prod1 >> LOG2_N);
        freq2 <= 20'(prod2 >> LOG2_N);
      end
      if (enable && (state == ST_DONE)) begin
        result_valid  <= 1'b1;
        peak1_bin     <= p1.bin;
        peak2_bin     <= p2.bin;
        peak1_mag     <= p1.mag;
        peak2_mag     <= p2.mag;
        peak1_freq_hz <= freq1;
        peak2_freq_hz <= freq2;
        peak2_found   <= (p2.mag > NOISE_FLOOR);
`ifdef SIG_SEP_WAVE_CLASS_EN
        peak1_is_tri  <= tri1;
        peak2_is_tri  <= tri2;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_separator.sv
// tb_fft_peak_separator: directed frames with hand-computed peaks. Each
// frame pushes its expected result into a queue; a monitor pops and compares
// whenever result_valid appears. Expectations follow SIG_SEP_WAVE_CLASS_EN.
module tb_fft_peak_separator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [27:0] magnitude = '0;
  logic [10:0] bin_index = '0;
  logic        magnitude_valid = 1'b0;
  logic        processing_done = 1'b0;
  logic        busy, result_valid;
  logic [10:0] peak1_bin, peak2_bin;
  logic [27:0] peak1_mag, peak2_mag;
  logic [19:0] peak1_freq_hz, peak2_freq_hz;
  logic        peak1_is_tri, peak2_is_tri, peak2_found;

`ifdef SIG_SEP_WAVE_CLASS_EN
  localparam int LAT    = 6;
  localparam bit TRI_ON = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit TRI_ON = 1'b0;
`endif

  typedef struct {
    int p1_bin; int p1_mag; int p1_freq; int p1_tri;
    int p2_bin; int p2_mag; int p2_freq; int p2_tri;
    int found;  bit chk_p2;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  logic [27:0] frame_mag [0:2047];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fft_peak_separator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .magnitude       (magnitude),
    .bin_index       (bin_index),
    .magnitude_valid (magnitude_valid),
    .processing_done (processing_done),
    .busy            (busy),
    .result_valid    (result_valid),
    .peak1_bin       (peak1_bin),
    .peak2_bin       (peak2_bin),
    .peak1_mag       (peak1_mag),
    .peak2_mag       (peak2_mag),
    .peak1_freq_hz   (peak1_freq_hz),
    .peak2_freq_hz   (peak2_freq_hz),
    .peak1_is_tri    (peak1_is_tri),
    .peak2_is_tri    (peak2_is_tri),
    .peak2_found     (peak2_found)
  );

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic fillFrame(input int def);
    for (int i = 0; i < 2048; i++) frame_mag[i] = 28'(def);
  endtask

  task automatic pushExp(input int b1, input int m1, input int f1, input int t1,
                         input int b2, input int m2, input int f2, input int t2,
                         input int found, input bit chk2);
    exp_t e;
    e.p1_bin = b1; e.p1_mag = m1; e.p1_freq = f1; e.p1_tri = TRI_ON ? t1 : 0;
    e.p2_bin = b2; e.p2_mag = m2; e.p2_freq = f2; e.p2_tri = TRI_ON ? t2 : 0;
    e.found = found; e.chk_p2 = chk2;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int first, input int last, input bit done);
    for (int b = first; b <= last; b++) begin
      @(negedge clk);
      magnitude_valid = 1'b1;
      bin_index       = 11'(b);
      magnitude       = frame_mag[b];
      processing_done = done && (b == last);
      if (done && (b == last)) done_cyc = cyc + 1;
    end
    @(negedge clk);
    magnitude_valid = 1'b0;
    processing_done = 1'b0;
  endtask

  task automatic waitResult();
    int n = 0;
    while ((sb.size() != 0) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL result_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every result_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_result_valid: got 1, expected 0");
      end else begin
        mon_e = sb.pop_front();
        checkOutput("latency",        cyc - done_cyc,         LAT);
        checkOutput("busy_at_result", int'(busy),             0);
        checkOutput("peak1_bin",      int'(peak1_bin),        mon_e.p1_bin);
        checkOutput("peak1_mag",      int'(peak1_mag),        mon_e.p1_mag);
        checkOutput("peak1_freq",     int'(peak1_freq_hz),    mon_e.p1_freq);
        checkOutput("peak1_is_tri",   int'(peak1_is_tri),     mon_e.p1_tri);
        checkOutput("peak2_found",    int'(peak2_found),      mon_e.found);
        if (mon_e.chk_p2) begin
          checkOutput("peak2_bin",    int'(peak2_bin),        mon_e.p2_bin);
          checkOutput("peak2_mag",    int'(peak2_mag),        mon_e.p2_mag);
          checkOutput("peak2_freq",   int'(peak2_freq_hz),    mon_e.p2_freq);
          checkOutput("peak2_is_tri", int'(peak2_is_tri),     mon_e.p2_tri);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",         int'(busy),          0);
    checkOutput("reset_result_valid", int'(result_valid),  0);
    checkOutput("reset_peak1_bin",    int'(peak1_bin),     0);
    checkOutput("reset_peak2_mag",    int'(peak2_mag),     0);
    checkOutput("reset_peak1_freq",   int'(peak1_freq_hz), 0);
    checkOutput("reset_peak2_found",  int'(peak2_found),   0);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    $display("[TB] two tones");
    fillFrame(10);
    frame_mag[123] = 28'd50000; frame_mag[246] = 28'd30000; frame_mag[738] = 28'd3300;
    pushExp(123, 50000, 30029, 0, 246, 30000, 60058, 1, 1, 1'b1);
    applyStimulus(0, 10, 1'b0);
    checkOutput("busy_in_frame", int'(busy), 1);
    applyStimulus(11, 2047, 1'b1);
    waitResult();

    $display("[TB] leakage around peak1");
    fillFrame(10);
    frame_mag[122] = 28'd40000; frame_mag[123] = 28'd50000;
    frame_mag[124] = 28'd45000; frame_mag[300] = 28'd20000;
    pushExp(123, 50000, 30029, 0, 300, 20000, 73242, 0, 1, 1'b1);
    applyStimulus(0, 2047, 1'b1);
    waitResult();

    $display("[TB] single tone");
    fillFrame(500);
    frame_mag[200] = 28'd50000;
    pushExp(200, 50000, 48828, 0, 0, 0, 0, 0, 0, 1'b0);
    applyStimulus(0, 2047, 1'b1);
    waitResult();

    $display("[TB] tie resolves to lower bin");
    fillFrame(10);
    frame_mag[100] = 28'd9000; frame_mag[400] = 28'd9000;
    pushExp(100, 9000, 24414, 0, 400, 9000, 97656, 0, 1, 1'b1);
    applyStimulus(0, 2047, 1'b1);
    waitResult();

    $display("[TB] ignored bins and out-of-range harmonic");
    fillFrame(10);
    for (int i = 0; i < 4; i++) frame_mag[i] = 28'd1000000;
    frame_mag[1500] = 28'd1000000;
    frame_mag[176]  = 28'd1000;
    frame_mag[250]  = 28'd7000;
    frame_mag[400]  = 28'd8000;
    pushExp(400, 8000, 97656, 0, 250, 7000, 61035, 0, 1, 1'b1);
    applyStimulus(0, 2047, 1'b1);
    waitResult();

    $display("[TB] enable dropped mid-frame");
    fillFrame(10);
    frame_mag[50] = 28'd99999;
    applyStimulus(0, 300, 1'b0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_busy",         int'(busy),         0);
    checkOutput("abort_peak1_held",   int'(peak1_bin),    400);
    checkOutput("abort_peak1_mag",    int'(peak1_mag),    8000);
    checkOutput("abort_result_valid", int'(result_valid), 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-frame");
    fillFrame(10);
    frame_mag[500] = 28'd90000;
    applyStimulus(0, 700, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_peak1_bin", int'(peak1_bin),   0);
    checkOutput("midreset_busy",      int'(busy),        0);
    checkOutput("midreset_found",     int'(peak2_found), 0);
    rst_n = 1'b1;
    @(negedge clk);
    fillFrame(10);
    frame_mag[150] = 28'd60000; frame_mag[300] = 28'd20000; frame_mag[450] = 28'd5000;
    pushExp(150, 60000, 36621, 1, 300, 20000, 73242, 0, 1, 1'b1);
    applyStimulus(0, 2047, 1'b1);
    waitResult();

    $display("[TB] bin 0 restarts the frame");
    fillFrame(10);
    frame_mag[500] = 28'd90000;
    applyStimulus(0, 600, 1'b0);
    fillFrame(10);
    frame_mag[60] = 28'd30000; frame_mag[180] = 28'd4000; frame_mag[800] = 28'd25000;
    pushExp(60, 30000, 14648, 1, 800, 25000, 195312, 0, 1, 1'b1);
    applyStimulus(0, 2047, 1'b1);
    waitResult();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
